// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus between NREQ requesters, the arbiter and one FIFO write port.
// A requester word moves when req[i] && gnt[i]; req and its req_data slice stay stable until granted.
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  fifo_full;
  logic                  fifo_read_en;
  logic                  fifo_write_en;
  logic [WIDTH-1:0]      fifo_write_data;

  modport master (
    output req, req_data, fifo_full, fifo_read_en,
    input  gnt, fifo_write_en, fifo_write_data
  );

  modport slave (
    input  req, req_data, fifo_full, fifo_read_en,
    output gnt, fifo_write_en, fifo_write_data
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NREQ requesters.
// Grants are combinational; an owner keeps the port for up to MAX_BURST words.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4,
  localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  fifo_wr_arbiter_if.slave bus,
  output logic [IW-1:0]    owner,
  output logic             busy
);

  localparam logic [0:0]    S_IDLE  = 1'b0;
  localparam logic [0:0]    S_BURST = 1'b1;
  localparam int            CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [IW-1:0] LAST    = IW'(NREQ - 1);
  localparam logic [IW:0]   NREQ_W  = (IW + 1)'(NREQ);

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          writable;
  logic          hold;
  logic          found;
  logic          grant;
  logic [IW-1:0] cand;
  logic [IW:0]   srch_sum;

  // A full FIFO still takes a word when it is being read in the same cycle.
  assign writable = !bus.fifo_full || bus.fifo_read_en;
  assign hold     = (state_q == S_BURST) && bus.req[owner_q] && (cnt_q < CNT_MAX);

  always_comb begin
    found    = 1'b0;
    cand     = owner_q;
    srch_sum = '0;
    if (hold) begin
      found = 1'b1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        srch_sum = {1'b0, ptr_q} + (IW + 1)'(k);
        if (srch_sum >= NREQ_W) srch_sum = srch_sum - NREQ_W;
        if (!found && bus.req[srch_sum[IW-1:0]]) begin
          found = 1'b1;
          cand  = srch_sum[IW-1:0];
        end
      end
    end
  end

  assign grant = !rst && enable && writable && found;

  always_comb begin
    bus.gnt             = '0;
    bus.fifo_write_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant && (cand == IW'(i))) begin
        bus.gnt[i]          = 1'b1;
        bus.fifo_write_data = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.fifo_write_en = grant;

  // Stalls (no enable or no room) freeze everything so the burst is not charged.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (grant) begin
      if (hold) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        state_d = S_BURST;
        owner_d = cand;
        cnt_d   = CNT_ONE;
        ptr_d   = (cand == LAST) ? '0 : cand + 1'b1;
      end
    end else if (enable && writable && (state_q == S_BURST) && !bus.req[owner_q]) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign owner = owner_q;
  assign busy  = (state_q == S_BURST);

endmodule
